poke_engine: RTL



---
 rtl/poke_pkg.sv | 19 +
 rtl/poke_engine.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/poke_pkg.sv
// Shared definitions for the poke engine.
// Holds the controller state encoding and the AXI4 write-channel constants
// (response codes, burst type) used by poke_engine.
package poke_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCheck = 2'd1,
        StXfer  = 2'd2,
        StWaitB = 2'd3
    } poke_state_e;

    localparam logic [1:0] AxiRespOkay   = 2'd0;
    localparam logic [1:0] AxiRespSlverr = 2'd2;
    localparam logic [1:0] AxiRespDecerr = 2'd3;

    localparam logic [1:0] AxiBurstIncr = 2'd1;

endpackage

// File: rtl/poke_engine.sv
// Poke engine: performs one 32-bit write into shared memory per start pulse.
// A (row, entry) coordinate is turned into a byte address and issued as a
// single-beat, byte-strobed AXI4 write.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   row_i, entry_i     target coordinate, sampled on start_i
//   value_i            32-bit data, sampled on start_i
//   start_i            one-cycle request pulse (ignored unless idle)
//   busy_o             operation in progress
//   error_o            result of last operation (bad entry or non-OKAY BRESP)
//   m_axi_aw*_o/_i     AXI4 write address channel
//   m_axi_w*_o/_i      AXI4 write data channel
//   m_axi_b*_o/_i      AXI4 write response channel
module poke_engine
    import poke_pkg::*;
#(
    parameter int unsigned   AW        = 64,
    parameter int unsigned   DW        = 512,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter int unsigned   ROW_BYTES = 2048
) (
    input  logic            clk,
    input  logic            resetn,

    input  logic [31:0]     row_i,
    input  logic [31:0]     entry_i,
    input  logic [31:0]     value_i,
    input  logic            start_i,
    output logic            busy_o,
    output logic            error_o,

    output logic [AW-1:0]   m_axi_awaddr_o,
    output logic [7:0]      m_axi_awlen_o,
    output logic [2:0]      m_axi_awsize_o,
    output logic [1:0]      m_axi_awburst_o,
    output logic            m_axi_awvalid_o,
    input  logic            m_axi_awready_i,

    output logic [DW-1:0]   m_axi_wdata_o,
    output logic [DW/8-1:0] m_axi_wstrb_o,
    output logic            m_axi_wlast_o,
    output logic            m_axi_wvalid_o,
    input  logic            m_axi_wready_i,

    input  logic [1:0]      m_axi_bresp_i,
    input  logic            m_axi_bvalid_i,
    output logic            m_axi_bready_o
);

    localparam int unsigned StrbW         = DW / 8;
    localparam int unsigned LaneW         = $clog2(StrbW);
    localparam int unsigned RowShift      = $clog2(ROW_BYTES);
    localparam logic [31:0] EntriesPerRow = 32'(ROW_BYTES / 4);

    poke_state_e   state_q, state_d;
    logic [AW-1:0] byte_addr_q, byte_addr_d;
    logic [31:0]   entry_q, entry_d;
    logic [31:0]   value_q, value_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;

    always_comb begin
        state_d     = state_q;
        byte_addr_d = byte_addr_q;
        entry_d     = entry_q;
        value_d     = value_q;
        error_d     = error_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    entry_d     = entry_i;
                    value_d     = value_i;
                    // Row and entry scaling are powers of two; wraps mod 2^AW.
                    byte_addr_d = BASE_ADDR + (AW'(row_i) << RowShift) + (AW'(entry_i) << 2);
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (entry_q >= EntriesPerRow) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    error_d   = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = StXfer;
                end
            end
            StXfer: begin
                // AW and W complete independently; move on once both are done.
                if (awvalid_q && m_axi_awready_i) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready_i)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = StWaitB;
                end
            end
            StWaitB: begin
                if (m_axi_bvalid_i) begin
                    error_d  = (m_axi_bresp_i != AxiRespOkay);
                    bready_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // busy covers the whole operation plus the cycle in which the final
        // error value first becomes visible.
        busy_d = (state_d != StIdle) || (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            byte_addr_q <= '0;
            entry_q     <= '0;
            value_q     <= '0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_addr_q <= byte_addr_d;
            entry_q     <= entry_d;
            value_q     <= value_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
        end
    end

    // Address/strobe/data derive only from registers captured at start, so they
    // stay stable for as long as the corresponding VALID is high.
    assign m_axi_awaddr_o  = {byte_addr_q[AW-1:LaneW], {LaneW{1'b0}}};
    assign m_axi_awlen_o   = 8'd0;
    assign m_axi_awsize_o  = 3'(LaneW);
    assign m_axi_awburst_o = AxiBurstIncr;
    assign m_axi_awvalid_o = awvalid_q;

    assign m_axi_wdata_o   = {(DW / 32){value_q}};
    assign m_axi_wstrb_o   = StrbW'(4'hF) << byte_addr_q[LaneW-1:0];
    assign m_axi_wlast_o   = 1'b1;
    assign m_axi_wvalid_o  = wvalid_q;

    assign m_axi_bready_o  = bready_q;

    assign busy_o  = busy_q;
    assign error_o = error_q;

endmodule
